mem_arbiter: RTL and testbench

- Registered arbiter between the instruction cache, the data cache and the single-ported RAM.
- Accepts word-level read/write requests from both caches, grants one at a time and holds that grant until the RAM reports completion.
- Returns load data and wait status to the granted cache.
- Sits directly downstream of the data cache's memory-side interface; it is the only block that drives the RAM.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered arbiter granting instruction/data cache word requests onto a single-ported RAM.
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests (default build: fixed data-cache priority).
module mem_arbiter #(
    parameter int ERR_LIMIT = 16,
    parameter int CNT_W     = 5
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_e;

    localparam logic [1:0]       RAM_ACCESS = 2'd2;
    localparam logic [1:0]       RAM_ERROR  = 2'd3;
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(ERR_LIMIT);

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        store_q, store_d;
    logic               wen_q, wen_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               err_q, err_d, err_now;
    logic               d_req, serving, granted_req, done, pick_d;
`ifdef MEM_ARB_RR_EN
    logic               last_q, last_d;   // 1: data cache was granted last
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif

        d_req       = dREN | dWEN;
        serving     = (state_q == DSERV) || (state_q == ISERV);
        granted_req = (state_q == DSERV) ? d_req : iREN;
        done        = serving && (ramstate == RAM_ACCESS);
        cnt_inc     = cnt_q + 1'b1;
        // Raised during the ERR_LIMIT-th error cycle itself, then held by err_q.
        err_now     = serving && granted_req && (ramstate == RAM_ERROR)
                      && ((cnt_inc == LIMIT) || (cnt_q == LIMIT));

`ifdef MEM_ARB_RR_EN
        pick_d = d_req && !(iREN && last_q);
`else
        pick_d = d_req;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = DSERV;
                    addr_d  = daddr;
                    store_d = dstore;
                    wen_d   = dWEN;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b1;
`endif
                end else if (iREN) begin
                    state_d = ISERV;
                    addr_d  = iaddr;
                    store_d = '0;
                    wen_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b0;
`endif
                end
            end
            DSERV, ISERV: begin
                // Completion wins over a same-cycle request drop; otherwise a drop aborts.
                if (done || !granted_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((ramstate == RAM_ERROR) && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_q | err_now;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // RAM side is driven purely from the registered request.
    assign ramREN   = serving && !wen_q;
    assign ramWEN   = serving && wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    assign dwait   = !(done && (state_q == DSERV));
    assign iwait   = !(done && (state_q == ISERV));
    assign dload   = (state_q == DSERV) ? ramload : '0;
    assign iload   = (state_q == ISERV) ? ramload : '0;
    assign arb_err = err_q | err_now;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: read, contention, write, abort, error limit and async reset.
module tb_mem_arbiter;

    localparam int         ERR_LIMIT  = 16;
    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    logic        CLK, nRST;
    logic        dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr, ramload;
    logic [1:0]  ramstate;
    logic        dwait, iwait, ramREN, ramWEN, arb_err;
    logic [31:0] dload, iload, ramaddr, ramstore;
    logic [3:0]  ctl;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ERR_LIMIT(ERR_LIMIT), .CNT_W(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    // {dwait, iwait, ramREN, ramWEN}
    assign ctl = {dwait, iwait, ramREN, ramWEN};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL reset_ctl got %b exp 1100", ctl); end
        checks++;
        if ({ramaddr, ramstore, dload, iload, arb_err} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h store=%h dload=%h iload=%h err=%b exp all 0",
                     ramaddr, ramstore, dload, iload, arb_err);
        end
        #2 nRST = 1'b1;
        step(); #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL post_reset_idle got %b exp 1100", ctl); end
    endtask

    task automatic test_single_read();
        step(); iREN = 1'b1; iaddr = 32'h40; ramstate = RAM_FREE; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL read_idle got %b exp 1100", ctl); end
        for (int i = 0; i < 3; i++) begin
            step(); ramstate = RAM_BUSY; iaddr = 32'h99; #1;
            checks++;
            if (ctl !== 4'b1110 || ramaddr !== 32'h40 || iload !== 32'h0) begin
                errors++;
                $display("FAIL read_busy%0d got ctl=%b addr=%h iload=%h exp 1110 00000040 0",
                         i, ctl, ramaddr, iload);
            end
        end
        step(); ramstate = RAM_ACCESS; ramload = 32'hDEADBEEF; #1;
        checks++;
        if (ctl !== 4'b1010 || iload !== 32'hDEADBEEF || dload !== 32'h0) begin
            errors++;
            $display("FAIL read_access got ctl=%b iload=%h dload=%h exp 1010 deadbeef 0", ctl, iload, dload);
        end
        step(); iREN = 1'b0; ramstate = RAM_FREE; #1;
        checks++;
        if (ctl !== 4'b1100 || iload !== 32'h0) begin
            errors++;
            $display("FAIL read_back_idle got ctl=%b iload=%h exp 1100 0", ctl, iload);
        end
    endtask

    task automatic test_back_to_back();
        step(); dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h300;
        ramstate = RAM_ACCESS; ramload = 32'h55; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL b2b_idle0 got %b exp 1100", ctl); end
        step(); #1;
        checks++;
        if (ctl !== 4'b0110 || ramaddr !== 32'h200 || dload !== 32'h55 || iload !== 32'h0) begin
            errors++;
            $display("FAIL b2b_first got ctl=%b addr=%h dload=%h iload=%h exp 0110 00000200 55 0",
                     ctl, ramaddr, dload, iload);
        end
        step(); #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL b2b_bubble got %b exp 1100", ctl); end
        step(); #1;
`ifdef MEM_ARB_RR_EN
        checks++;
        if (ctl !== 4'b1010 || ramaddr !== 32'h300 || iload !== 32'h55 || dload !== 32'h0) begin
            errors++;
            $display("FAIL b2b_second got ctl=%b addr=%h iload=%h dload=%h exp 1010 00000300 55 0",
                     ctl, ramaddr, iload, dload);
        end
`else
        checks++;
        if (ctl !== 4'b0110 || ramaddr !== 32'h200 || dload !== 32'h55 || iload !== 32'h0) begin
            errors++;
            $display("FAIL b2b_second got ctl=%b addr=%h dload=%h iload=%h exp 0110 00000200 55 0",
                     ctl, ramaddr, dload, iload);
        end
`endif
        step(); dREN = 1'b0; iREN = 1'b0; ramstate = RAM_FREE; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL b2b_end got %b exp 1100", ctl); end
    endtask

    task automatic test_write();
        step(); dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL write_idle got %b exp 1100", ctl); end
        step(); ramstate = RAM_BUSY; dstore = 32'h0; daddr = 32'h999; #1;
        checks++;
        if (ctl !== 4'b1101 || ramaddr !== 32'h100 || ramstore !== 32'h12345678) begin
            errors++;
            $display("FAIL write_busy got ctl=%b addr=%h store=%h exp 1101 00000100 12345678",
                     ctl, ramaddr, ramstore);
        end
        step(); ramstate = RAM_ACCESS; #1;
        checks++;
        if (ctl !== 4'b0101 || ramstore !== 32'h12345678) begin
            errors++;
            $display("FAIL write_access got ctl=%b store=%h exp 0101 12345678", ctl, ramstore);
        end
        step(); dWEN = 1'b0; ramstate = RAM_FREE; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL write_back_idle got %b exp 1100", ctl); end
    endtask

    task automatic test_abort();
        step(); dREN = 1'b1; daddr = 32'h400; ramstate = RAM_BUSY; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL abort_idle got %b exp 1100", ctl); end
        step(); #1;
        checks++;
        if (ctl !== 4'b1110 || ramaddr !== 32'h400) begin
            errors++;
            $display("FAIL abort_serve got ctl=%b addr=%h exp 1110 00000400", ctl, ramaddr);
        end
        step(); dREN = 1'b0; iREN = 1'b1; iaddr = 32'h500; #1;
        checks++;
        if (ctl !== 4'b1110) begin errors++; $display("FAIL abort_drop got %b exp 1110", ctl); end
        step(); #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL abort_strobe_off got %b exp 1100", ctl); end
        step(); ramstate = RAM_ACCESS; ramload = 32'hCAFEF00D; #1;
        checks++;
        if (ctl !== 4'b1010 || ramaddr !== 32'h500 || iload !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL abort_next_read got ctl=%b addr=%h iload=%h exp 1010 00000500 cafef00d",
                     ctl, ramaddr, iload);
        end
        step(); iREN = 1'b0; ramstate = RAM_FREE; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL abort_end got %b exp 1100", ctl); end
    endtask

    task automatic test_error();
        step(); iREN = 1'b1; iaddr = 32'h600; ramstate = RAM_ERROR; #1;
        checks++;
        if (ctl !== 4'b1100 || arb_err !== 1'b0) begin
            errors++;
            $display("FAIL err_idle got ctl=%b err=%b exp 1100 0", ctl, arb_err);
        end
        for (int k = 1; k <= ERR_LIMIT; k++) begin
            logic exp_err;
            exp_err = (k == ERR_LIMIT);
            step(); #1;
            checks++;
            if (ctl !== 4'b1110 || arb_err !== exp_err) begin
                errors++;
                $display("FAIL err_cycle%0d got ctl=%b err=%b exp 1110 %b", k, ctl, arb_err, exp_err);
            end
        end
        step(); ramstate = RAM_ACCESS; ramload = 32'h77; #1;
        checks++;
        if (ctl !== 4'b1010 || iload !== 32'h77 || arb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_access got ctl=%b iload=%h err=%b exp 1010 77 1", ctl, iload, arb_err);
        end
        step(); iREN = 1'b0; ramstate = RAM_FREE; #1;
        checks++;
        if (ctl !== 4'b1100 || arb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got ctl=%b err=%b exp 1100 1", ctl, arb_err);
        end
    endtask

    task automatic test_reset_mid();
        step(); dREN = 1'b1; daddr = 32'h700; dstore = 32'hABCD; ramstate = RAM_BUSY; ramload = 32'h11; #1;
        checks++;
        if (ctl !== 4'b1100) begin errors++; $display("FAIL rst_mid_idle got %b exp 1100", ctl); end
        step(); #1;
        checks++;
        if (ctl !== 4'b1110 || ramaddr !== 32'h700 || ramstore !== 32'hABCD || dload !== 32'h11) begin
            errors++;
            $display("FAIL rst_mid_serve got ctl=%b addr=%h store=%h dload=%h exp 1110 00000700 0000abcd 11",
                     ctl, ramaddr, ramstore, dload);
        end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if (ctl !== 4'b1100 || {ramaddr, ramstore, dload, iload, arb_err} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got ctl=%b addr=%h store=%h dload=%h err=%b exp 1100 and zeros",
                     ctl, ramaddr, ramstore, dload, arb_err);
        end
        dREN = 1'b0;
        #1 nRST = 1'b1;
        step(); #1;
        checks++;
        if (ctl !== 4'b1100 || arb_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after got ctl=%b err=%b exp 1100 0", ctl, arb_err);
        end
    endtask

    initial begin
        nRST     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        iREN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        iaddr    = '0;
        ramload  = '0;
        ramstate = RAM_FREE;

        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_abort();
        test_error();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
